// File: rtl/floo_axis_vc_scheduler_if.sv
//------------------------------------------------------------------------------
// floo_axis_vc_scheduler_if : VC handshake, credit and status bundle. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface floo_axis_vc_scheduler_if #(
  parameter int unsigned NumCredits = 8
);
  localparam int unsigned CntWidth = $clog2(NumCredits + 1);

  logic                req_valid_i;
  logic                rsp_valid_i;
  logic                req_gnt_o;
  logic                rsp_gnt_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic                sel_o;
  logic                credit_req_i;
  logic                credit_rsp_i;
  logic [CntWidth-1:0] credits_req_o;
  logic [CntWidth-1:0] credits_rsp_o;
  logic                overflow_o;

  modport slave (
    input  req_valid_i, rsp_valid_i, out_ready_i, credit_req_i, credit_rsp_i,
    output req_gnt_o, rsp_gnt_o, out_valid_o, sel_o, credits_req_o, credits_rsp_o,
           overflow_o
  );

  modport master (
    output req_valid_i, rsp_valid_i, out_ready_i, credit_req_i, credit_rsp_i,
    input  req_gnt_o, rsp_gnt_o, out_valid_o, sel_o, credits_req_o, credits_rsp_o,
           overflow_o
  );
endinterface

`default_nettype wire

// File: rtl/floo_axis_vc_scheduler.sv
//------------------------------------------------------------------------------
// floo_axis_vc_scheduler : credit-based REQ/RSP scheduler for the shared AXIS link. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module floo_axis_vc_scheduler #(
  parameter int unsigned NumCredits = 8,
  parameter int unsigned MaxBurst   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  floo_axis_vc_scheduler_if.slave bus
);
  localparam int unsigned CntWidth   = $clog2(NumCredits + 1);
  localparam int unsigned BurstWidth = $clog2(MaxBurst + 1);
  localparam logic [CntWidth-1:0]   CntFull   = CntWidth'(NumCredits);
  localparam logic [CntWidth-1:0]   CntOne    = CntWidth'(1);
  localparam logic [BurstWidth-1:0] BurstFull = BurstWidth'(MaxBurst);
  localparam logic [BurstWidth-1:0] BurstOne  = BurstWidth'(1);

  typedef enum logic {OWN_RSP = 1'b0, OWN_REQ = 1'b1} owner_e;

  owner_e                owner_q, owner_d;
  logic [BurstWidth-1:0] burst_q, burst_d;
  logic                  lock_q, lock_d;
  logic                  locked_sel_q, locked_sel_d;
  logic [CntWidth-1:0]   credits_req_q, credits_req_d;
  logic [CntWidth-1:0]   credits_rsp_q, credits_rsp_d;
  logic                  overflow_q, overflow_d;

  logic elig_req, elig_rsp, elig_own, elig_oth, own_bit;
  logic offer, chosen, hs, dec_req, dec_rsp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q       <= OWN_REQ;
      burst_q       <= '0;
      lock_q        <= 1'b0;
      locked_sel_q  <= 1'b0;
      credits_req_q <= CntFull;
      credits_rsp_q <= CntFull;
      overflow_q    <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      burst_q       <= burst_d;
      lock_q        <= lock_d;
      locked_sel_q  <= locked_sel_d;
      credits_req_q <= credits_req_d;
      credits_rsp_q <= credits_rsp_d;
      overflow_q    <= overflow_d;
    end
  end

  always_comb begin
    elig_req = bus.req_valid_i && (credits_req_q != '0);
    elig_rsp = bus.rsp_valid_i && (credits_rsp_q != '0);
    own_bit  = (owner_q == OWN_REQ);
    elig_own = own_bit ? elig_req : elig_rsp;
    elig_oth = own_bit ? elig_rsp : elig_req;

    offer  = 1'b0;
    chosen = own_bit;
    // burst_q == 0 only right after reset: the owner has no running burst, so a tie goes to the other side
    if (lock_q) begin
      offer  = 1'b1;
      chosen = locked_sel_q;
    end else if (elig_own && (((burst_q != '0) && (burst_q < BurstFull)) || !elig_oth)) begin
      offer  = 1'b1;
      chosen = own_bit;
    end else if (elig_oth) begin
      offer  = 1'b1;
      chosen = !own_bit;
    end

    hs      = offer && bus.out_ready_i;
    dec_req = hs && chosen;
    dec_rsp = hs && !chosen;

    owner_d      = owner_q;
    burst_d      = burst_q;
    lock_d       = lock_q;
    locked_sel_d = locked_sel_q;
    if (offer && !bus.out_ready_i) begin
      lock_d       = 1'b1;
      locked_sel_d = chosen;
    end
    if (hs) begin
      lock_d = 1'b0;
      if (chosen == own_bit) begin
        if (!elig_oth)                burst_d = BurstOne;
        else if (burst_q != BurstFull) burst_d = burst_q + BurstOne;
      end else begin
        owner_d = chosen ? OWN_REQ : OWN_RSP;
        burst_d = BurstOne;
      end
    end

    credits_req_d = credits_req_q;
    credits_rsp_d = credits_rsp_q;
    overflow_d    = overflow_q;
    if (dec_req && !bus.credit_req_i) begin
      credits_req_d = credits_req_q - CntOne;
    end else if (!dec_req && bus.credit_req_i) begin
      if (credits_req_q == CntFull) overflow_d    = 1'b1;
      else                          credits_req_d = credits_req_q + CntOne;
    end
    if (dec_rsp && !bus.credit_rsp_i) begin
      credits_rsp_d = credits_rsp_q - CntOne;
    end else if (!dec_rsp && bus.credit_rsp_i) begin
      if (credits_rsp_q == CntFull) overflow_d    = 1'b1;
      else                          credits_rsp_d = credits_rsp_q + CntOne;
    end
  end

  // Handshake outputs are forced low for the whole reset window, even mid-cycle
  assign bus.out_valid_o   = offer && !rst_i;
  assign bus.sel_o         = offer && chosen && !rst_i;
  assign bus.req_gnt_o     = dec_req && !rst_i;
  assign bus.rsp_gnt_o     = dec_rsp && !rst_i;
  assign bus.credits_req_o = credits_req_q;
  assign bus.credits_rsp_o = credits_rsp_q;
  assign bus.overflow_o    = overflow_q;

endmodule

`default_nettype wire
